food_spawn_ctrl: RTL
====================

# food_spawn_ctrl

Sequences the 5-bit LFSR PRNG to place a new food item on the snake grid. On request it draws X and Y candidates from the PRNG, rejects out-of-range values, and queries the snake-body occupancy checker over a req/ack handshake. It retries on collision up to a limit, then publishes the food coordinate to the game logic and renderer. It also drives the PRNG `load` strobe after reset.

## Interface
- `GRID_W`, default 20: playfield columns. Legal range 1..31.
- `GRID_H`, default 15: playfield rows. Legal range 1..31.
- `MAX_TRIES`, default 7: collision retries allowed after the first check. Legal range 0..31.
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `spawn_req` in 1: request a new food position. Accepted only in IDLE.
- `rnd` in 5: PRNG output (`num`).
- `prng_load` out 1: PRNG seed/load strobe.
- `occ_req` out 1: occupancy query valid.
- `occ_x`, `occ_y` out 5 each: candidate coordinate under query.
- `occ_ack` in 1: occupancy answer valid. Same-cycle ack is allowed.
- `occ_hit` in 1: candidate overlaps the snake. Sampled only when `occ_ack`=1.
- `food_x`, `food_y` out 5 each: published food coordinate.
- `food_valid` out 1: the food coordinate is valid.
- `done` out 1: one-cycle pulse on successful placement.
- `spawn_fail` out 1: one-cycle pulse when retries are exhausted.
- `busy` out 1: high whenever state ≠ IDLE.

## Operation
- FSM states: SEED, IDLE, GET_X, GET_Y, CHECK.
- While `rst`=1:
  - state is forced to SEED.
  - `food_x`=`food_y`=0; `food_valid`, `done`, `spawn_fail`, `occ_req` are 0.
  - retry counter `tries`=0; candidates `cx`=`cy`=0.
- SEED: `prng_load`=1 and `busy`=1. Unconditionally go to IDLE next cycle. `prng_load` is therefore high throughout reset plus the first cycle after `rst` falls.
- IDLE: on `spawn_req`=1, clear `food_valid`, set `tries`=0, go to GET_X. Otherwise hold. `spawn_req` in any other state is ignored (no queuing).
- Sample mapping: a 5-bit maximal LFSR never emits 0, so candidate = `rnd`−1.
  - X sample accepted iff 1 ≤ `rnd` ≤ `GRID_W`; Y sample accepted iff 1 ≤ `rnd` ≤ `GRID_H`.
  - Rejected samples cause a resample next cycle in the same state. Rejections do not count as tries.
- GET_X: on accept, latch `cx` = `rnd`−1 and go to GET_Y.
- GET_Y: on accept, latch `cy` = `rnd`−1 and go to CHECK.
- CHECK:
  - `occ_req`=1, `occ_x`=`cx`, `occ_y`=`cy`, all held stable until `occ_ack`.
  - On `occ_ack` with `occ_hit`=0: `food_x`←`cx`, `food_y`←`cy`, `food_valid`←1, `done` pulses next cycle, go to IDLE.
  - On `occ_ack` with `occ_hit`=1 and `tries` < `MAX_TRIES`: `tries`++, go to GET_X.
  - On `occ_ack` with `occ_hit`=1 and `tries` = `MAX_TRIES`: `spawn_fail` pulses next cycle, `food_valid` stays 0, go to IDLE.
  - Total occupancy checks per request never exceed `MAX_TRIES`+1.
- `occ_req` is 0 in every state other than CHECK. It drops the cycle after `occ_ack`.
- `food_x`/`food_y` hold their last value until the next successful placement. They are meaningful only while `food_valid`=1.
- Reset mid-operation (any state): abandon the request. `occ_req` drops at the next edge, and the SEED sequence repeats.

## Timing
- All outputs are registered or decoded from the state register only. There are no combinational paths from inputs to outputs.
- Best-case latency, with every sample in range, same-cycle ack and no hit:
  - `spawn_req` accepted at edge 0.
  - GET_X at cycle 1, GET_Y at cycle 2, CHECK (`occ_req`=1) at cycle 3.
  - `food_valid`=1 and `done`=1 at cycle 4.
- Each rejected sample adds 1 cycle. Each extra ack-wait cycle adds 1. Each collision retry adds at least 3 cycles (GET_X, GET_Y, CHECK).
- `busy` falls in the same cycle that `done` or `spawn_fail` is high (state = IDLE). A new `spawn_req` is accepted in that cycle.

## Test plan
Bench drives `rnd` directly for determinism, with `GRID_W`=20, `GRID_H`=15, `MAX_TRIES`=2.
- **Reset:** hold `rst` 3 cycles, then release.
  - `prng_load`=1 for 4 cycles total, then 0.
  - `busy` falls after 1 post-reset cycle.
  - `food_valid`=0, `food_x`=`food_y`=0, `occ_req`=0 throughout.
- **Clean spawn:** pulse `spawn_req`, `rnd`=5 then 9, `occ_ack`=1 with `occ_hit`=0 in the first CHECK cycle.
  - `occ_x`=4, `occ_y`=8 with `occ_req`=1 at cycle 3.
  - `food_x`=4, `food_y`=8, `food_valid`=1, single-cycle `done` at cycle 4.
- **Range rejection:** X stream `rnd`=0,21,31,20 → 3 stall cycles, `cx`=19. Y stream `rnd`=16,15 → 1 stall, `cy`=14. Result: `food_x`=19, `food_y`=14 at cycle 8.
- **Collision retry:** `occ_hit`=1 on checks 1 and 2, 0 on check 3, with distinct candidates per round.
  - Exactly 3 `occ_req` episodes.
  - Final `food_x`/`food_y` equal the third candidate; `spawn_fail` never pulses.
- **Exhaustion and handshake stall:** `occ_hit`=1 always, `occ_ack` delayed 2 cycles each time.
  - `occ_req` and `occ_x`/`occ_y` stay stable during each stall.
  - Exactly 3 checks, then one `spawn_fail` pulse; `food_valid`=0; `busy`=0.
- **Reset mid-CHECK:** assert `rst` while `occ_req`=1 and `occ_ack`=0.
  - `occ_req`=0 at the next edge, `prng_load`=1.
  - A `spawn_req` pulsed during reset is ignored.

Source files
------------

// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl: places a new food item on the snake grid.
// Draws X/Y candidates from the LFSR PRNG, rejects out-of-range samples,
// asks the snake-body occupancy checker over a req/ack handshake, retries
// on collision up to MAX_TRIES times and publishes the final coordinate.
// Every output comes either from a flop or from the state register alone.
module food_spawn_ctrl #(
  parameter int GRID_W    = 20,
  parameter int GRID_H    = 15,
  parameter int MAX_TRIES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spawn_req,
  input  logic [4:0] rnd,
  output logic       prng_load,
  output logic       occ_req,
  output logic [4:0] occ_x,
  output logic [4:0] occ_y,
  input  logic       occ_ack,
  input  logic       occ_hit,
  output logic [4:0] food_x,
  output logic [4:0] food_y,
  output logic       food_valid,
  output logic       done,
  output logic       spawn_fail,
  output logic       busy
);

  typedef enum logic [2:0] {
    SEED  = 3'd0,
    IDLE  = 3'd1,
    GET_X = 3'd2,
    GET_Y = 3'd3,
    CHECK = 3'd4
  } state_e;

  localparam logic [4:0] GRID_W_L    = 5'(GRID_W);
  localparam logic [4:0] GRID_H_L    = 5'(GRID_H);
  localparam logic [4:0] MAX_TRIES_L = 5'(MAX_TRIES);

  // A maximal 5-bit LFSR never emits 0, so sample s maps to coordinate s-1;
  // samples above the grid dimension are thrown away and redrawn.
  function automatic logic sample_ok(input logic [4:0] sample, input logic [4:0] limit);
    sample_ok = (sample != 5'd0) && (sample <= limit);
  endfunction

  state_e     state_q, state_d;
  logic [4:0] tries_q, tries_d;
  logic [4:0] cx_q, cx_d;
  logic [4:0] cy_q, cy_d;
  logic [4:0] food_x_q, food_x_d;
  logic [4:0] food_y_q, food_y_d;
  logic       food_valid_q, food_valid_d;
  logic       done_q, done_d;
  logic       fail_q, fail_d;

  // Next-state and datapath decisions for the spawn sequence.
  always_comb begin
    state_d      = state_q;
    tries_d      = tries_q;
    cx_d         = cx_q;
    cy_d         = cy_q;
    food_x_d     = food_x_q;
    food_y_d     = food_y_q;
    food_valid_d = food_valid_q;
    done_d       = 1'b0;
    fail_d       = 1'b0;
    case (state_q)
      SEED: begin
        state_d = IDLE;
      end
      IDLE: begin
        if (spawn_req) begin
          food_valid_d = 1'b0;
          tries_d      = 5'd0;
          state_d      = GET_X;
        end else begin
          state_d = IDLE;
        end
      end
      GET_X: begin
        if (sample_ok(rnd, GRID_W_L)) begin
          cx_d    = rnd - 5'd1;
          state_d = GET_Y;
        end else begin
          state_d = GET_X;
        end
      end
      GET_Y: begin
        if (sample_ok(rnd, GRID_H_L)) begin
          cy_d    = rnd - 5'd1;
          state_d = CHECK;
        end else begin
          state_d = GET_Y;
        end
      end
      CHECK: begin
        if (occ_ack) begin
          if (!occ_hit) begin
            food_x_d     = cx_q;
            food_y_d     = cy_q;
            food_valid_d = 1'b1;
            done_d       = 1'b1;
            state_d      = IDLE;
          end else if (tries_q < MAX_TRIES_L) begin
            tries_d = tries_q + 5'd1;
            state_d = GET_X;
          end else begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end
        end else begin
          state_d = CHECK;
        end
      end
      default: begin
        state_d = SEED;
      end
    endcase
  end

  // State and output registers; reset abandons any request and reseeds.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEED;
      tries_q      <= 5'd0;
      cx_q         <= 5'd0;
      cy_q         <= 5'd0;
      food_x_q     <= 5'd0;
      food_y_q     <= 5'd0;
      food_valid_q <= 1'b0;
      done_q       <= 1'b0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tries_q      <= tries_d;
      cx_q         <= cx_d;
      cy_q         <= cy_d;
      food_x_q     <= food_x_d;
      food_y_q     <= food_y_d;
      food_valid_q <= food_valid_d;
      done_q       <= done_d;
      fail_q       <= fail_d;
    end
  end

  assign prng_load  = (state_q == SEED);
  assign busy       = (state_q != IDLE);
  assign occ_req    = (state_q == CHECK);
  assign occ_x      = cx_q;
  assign occ_y      = cy_q;
  assign food_x     = food_x_q;
  assign food_y     = food_y_q;
  assign food_valid = food_valid_q;
  assign done       = done_q;
  assign spawn_fail = fail_q;

endmodule
